// File: rtl/core_ex_wbck_if.sv
// Write-back bundle for core_ex_wbck: the three result streams, long-latency
// issue, hazard check operands, the registered regfile write port and status.
interface core_ex_wbck_if #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
);
   logic               alu_wb_valid;
   logic               alu_wb_en;
   logic [RFIDX_W-1:0] alu_wb_idx;
   logic [XLEN-1:0]    alu_wb_dat;
   logic               alu_wb_ready;

   logic               lsu_wb_valid;
   logic [RFIDX_W-1:0] lsu_wb_idx;
   logic [XLEN-1:0]    lsu_wb_dat;
   logic               lsu_wb_ready;

   logic               mdu_wb_valid;
   logic [RFIDX_W-1:0] mdu_wb_idx;
   logic [XLEN-1:0]    mdu_wb_dat;
   logic               mdu_wb_ready;

   logic               lt_issue_valid;
   logic [RFIDX_W-1:0] lt_issue_idx;

   logic [RFIDX_W-1:0] chk_src1_idx;
   logic [RFIDX_W-1:0] chk_src2_idx;
   logic [RFIDX_W-1:0] chk_dest_idx;
   logic               hazard;

   logic               wb_dest_wen;
   logic [RFIDX_W-1:0] wb_dest_idx;
   logic [XLEN-1:0]    wb_dest_dat;

   logic               sb_err;

   modport master (
      output alu_wb_valid, alu_wb_en, alu_wb_idx, alu_wb_dat,
      input  alu_wb_ready,
      output lsu_wb_valid, lsu_wb_idx, lsu_wb_dat,
      input  lsu_wb_ready,
      output mdu_wb_valid, mdu_wb_idx, mdu_wb_dat,
      input  mdu_wb_ready,
      output lt_issue_valid, lt_issue_idx,
      output chk_src1_idx, chk_src2_idx, chk_dest_idx,
      input  hazard,
      input  wb_dest_wen, wb_dest_idx, wb_dest_dat,
      input  sb_err
   );

   modport slave (
      input  alu_wb_valid, alu_wb_en, alu_wb_idx, alu_wb_dat,
      output alu_wb_ready,
      input  lsu_wb_valid, lsu_wb_idx, lsu_wb_dat,
      output lsu_wb_ready,
      input  mdu_wb_valid, mdu_wb_idx, mdu_wb_dat,
      output mdu_wb_ready,
      input  lt_issue_valid, lt_issue_idx,
      input  chk_src1_idx, chk_src2_idx, chk_dest_idx,
      output hazard,
      output wb_dest_wen, wb_dest_idx, wb_dest_dat,
      output sb_err
   );
endinterface

// File: rtl/core_ex_wbck.sv
// Execute-stage write-back arbiter (LSU > MDU > ALU) feeding the single
// registered regfile write port, plus the long-latency pending-register
// scoreboard that drives the issue stall.
module core_ex_wbck #(
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5,
   parameter int RF_NUM  = 32
) (
   input  logic          clk,
   input  logic          rst,
   core_ex_wbck_if.slave wb
);

   logic               lsu_gnt;
   logic               mdu_gnt;
   logic               alu_gnt;
   logic               gnt_vld;
   logic               gnt_en;
   logic [RFIDX_W-1:0] gnt_idx;
   logic [XLEN-1:0]    gnt_dat;

   logic               wen_q;
   logic [RFIDX_W-1:0] idx_q;
   logic [XLEN-1:0]    dat_q;

   logic [RF_NUM-1:0]  pend_q;
   logic [RF_NUM-1:0]  pend_d;
   logic [RF_NUM-1:0]  set_vec;
   logic [RF_NUM-1:0]  clr_vec;
   logic               dup_issue;
   logic               err_q;
   logic               haz;

   // Fixed-priority grant and selection of the winning result
   always_comb begin
      lsu_gnt = wb.lsu_wb_valid;
      mdu_gnt = wb.mdu_wb_valid & ~wb.lsu_wb_valid;
      alu_gnt = wb.alu_wb_valid & ~wb.lsu_wb_valid & ~wb.mdu_wb_valid;
      gnt_vld = lsu_gnt | mdu_gnt | alu_gnt;
      gnt_en  = 1'b0;
      gnt_idx = '0;
      gnt_dat = '0;
      if (lsu_gnt) begin
         gnt_en  = 1'b1;
         gnt_idx = wb.lsu_wb_idx;
         gnt_dat = wb.lsu_wb_dat;
      end else if (mdu_gnt) begin
         gnt_en  = 1'b1;
         gnt_idx = wb.mdu_wb_idx;
         gnt_dat = wb.mdu_wb_dat;
      end else if (alu_gnt) begin
         gnt_en  = wb.alu_wb_en;
         gnt_idx = wb.alu_wb_idx;
         gnt_dat = wb.alu_wb_dat;
      end
   end

   assign wb.lsu_wb_ready = lsu_gnt;
   assign wb.mdu_wb_ready = mdu_gnt;
   assign wb.alu_wb_ready = alu_gnt;

   // Output stage: enable reloads every cycle, index/data only on a grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wen_q <= 1'b0;
         idx_q <= '0;
         dat_q <= '0;
      end else begin
         wen_q <= gnt_vld & gnt_en & (gnt_idx != '0);
         if (gnt_vld) begin
            idx_q <= gnt_idx;
            dat_q <= gnt_dat;
         end
      end
   end

   assign wb.wb_dest_wen = wen_q;
   assign wb.wb_dest_idx = idx_q;
   assign wb.wb_dest_dat = dat_q;

   // Scoreboard next state; a same-cycle set overrides the clear because the
   // issuing op is younger than the one retiring
   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      for (int i = 1; i < RF_NUM; i++) begin
         set_vec[i] = wb.lt_issue_valid && (wb.lt_issue_idx == RFIDX_W'(i));
         clr_vec[i] = (lsu_gnt && (wb.lsu_wb_idx == RFIDX_W'(i))) ||
                      (mdu_gnt && (wb.mdu_wb_idx == RFIDX_W'(i)));
      end
      dup_issue = |(set_vec & pend_q & ~clr_vec);
      pend_d    = ((pend_q & ~clr_vec) | set_vec) & {{(RF_NUM-1){1'b1}}, 1'b0};
   end

   // Pending bits and sticky double-issue error
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
         err_q  <= 1'b0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_q | dup_issue;
      end
   end

   assign wb.sb_err = err_q;

   // Stall while any nonzero operand is pending or is about to be written
   // by the output stage (the regfile does not bypass)
   always_comb begin
      logic [RFIDX_W-1:0] src [3];
      src[0] = wb.chk_src1_idx;
      src[1] = wb.chk_src2_idx;
      src[2] = wb.chk_dest_idx;
      haz = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (src[k] != '0) begin
            if (pend_q[src[k]] || (wen_q && (idx_q == src[k]))) begin
               haz = 1'b1;
            end
         end
      end
   end

   assign wb.hazard = haz;

endmodule

// File: tb/tb_core_ex_wbck.sv
// Bench for core_ex_wbck: directed scenarios plus random traffic, checked
// against a behavioural model (priority pick, pending set, last write) and a
// write-order scoreboard consumed by an independent monitor.
module tb_core_ex_wbck;

   logic clk;
   logic rst;

   core_ex_wbck_if #(.XLEN(32), .RFIDX_W(5)) bus ();

   core_ex_wbck #(.XLEN(32), .RFIDX_W(5), .RF_NUM(32)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] dat;
   } wr_t;

   wr_t         exp_q [$];
   int          n_tot  = 0;
   int          n_pass = 0;

   bit [31:0]   m_pend = '0;
   bit          m_last_v = 1'b0;
   logic [4:0]  m_last_idx = '0;
   bit          m_err = 1'b0;

   logic [31:0] rf [32] = '{default: 32'h0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Downstream regfile: written by the DUT's registered port
   always @(posedge clk) begin
      if (bus.wb_dest_wen) rf[bus.wb_dest_idx] <= bus.wb_dest_dat;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tot++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic bit m_haz(input logic [4:0] s);
      return (s != 5'd0) && (m_pend[s] || (m_last_v && (m_last_idx == s)));
   endfunction

   // Monitor: every regfile write must be the next one the model predicted
   initial begin
      forever begin
         @(negedge clk);
         if (bus.wb_dest_wen === 1'b1) begin
            wr_t e;
            n_tot++;
            if (exp_q.size() == 0) begin
               $display("FAIL wb_write: got idx %0d dat %h expected no write",
                        bus.wb_dest_idx, bus.wb_dest_dat);
            end else begin
               e = exp_q.pop_front();
               if (bus.wb_dest_idx !== e.idx || bus.wb_dest_dat !== e.dat)
                  $display("FAIL wb_write: got idx %0d dat %h expected idx %0d dat %h",
                           bus.wb_dest_idx, bus.wb_dest_dat, e.idx, e.dat);
               else n_pass++;
            end
         end
      end
   end

   task automatic clear_inputs();
      bus.alu_wb_valid   = 1'b0;
      bus.alu_wb_en      = 1'b0;
      bus.alu_wb_idx     = '0;
      bus.alu_wb_dat     = '0;
      bus.lsu_wb_valid   = 1'b0;
      bus.lsu_wb_idx     = '0;
      bus.lsu_wb_dat     = '0;
      bus.mdu_wb_valid   = 1'b0;
      bus.mdu_wb_idx     = '0;
      bus.mdu_wb_dat     = '0;
      bus.lt_issue_valid = 1'b0;
      bus.lt_issue_idx   = '0;
   endtask

   task automatic model_reset();
      m_pend   = '0;
      m_last_v = 1'b0;
      m_err    = 1'b0;
      exp_q.delete();
   endtask

   // One cycle: check combinational outputs mid-cycle, advance the model at
   // the edge, then retire whatever the model says was accepted.
   task automatic step();
      int          g;
      logic [4:0]  gi;
      logic [31:0] gd;
      logic        ge;
      @(negedge clk);
      g = bus.lsu_wb_valid ? 1 : bus.mdu_wb_valid ? 2 : bus.alu_wb_valid ? 3 : 0;
      chk("lsu_ready", bus.lsu_wb_ready, g == 1);
      chk("mdu_ready", bus.mdu_wb_ready, g == 2);
      chk("alu_ready", bus.alu_wb_ready, g == 3);
      chk("hazard", bus.hazard,
          m_haz(bus.chk_src1_idx) | m_haz(bus.chk_src2_idx) | m_haz(bus.chk_dest_idx));
      chk("sb_err", bus.sb_err, m_err);
      @(posedge clk);
      if (!rst) begin
         gi = '0; gd = '0; ge = 1'b0;
         case (g)
            1: begin gi = bus.lsu_wb_idx; gd = bus.lsu_wb_dat; ge = 1'b1; end
            2: begin gi = bus.mdu_wb_idx; gd = bus.mdu_wb_dat; ge = 1'b1; end
            3: begin gi = bus.alu_wb_idx; gd = bus.alu_wb_dat; ge = bus.alu_wb_en; end
            default: ;
         endcase
         m_last_v   = ge && (gi != 5'd0);
         m_last_idx = gi;
         if (m_last_v) exp_q.push_back('{gi, gd});
         if (g == 1 || g == 2) m_pend[gi] = 1'b0;
         if (bus.lt_issue_valid && bus.lt_issue_idx != 5'd0) begin
            if (m_pend[bus.lt_issue_idx]) m_err = 1'b1;
            m_pend[bus.lt_issue_idx] = 1'b1;
         end
      end
      #1;
      if (!rst) begin
         if (g == 1) bus.lsu_wb_valid = 1'b0;
         if (g == 2) bus.mdu_wb_valid = 1'b0;
         if (g == 3) bus.alu_wb_valid = 1'b0;
         bus.lt_issue_valid = 1'b0;
      end
   endtask

   task automatic set_chk(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
      bus.chk_src1_idx = s1;
      bus.chk_src2_idx = s2;
      bus.chk_dest_idx = d;
   endtask

   initial begin
      logic [31:0] saved;
      clear_inputs();
      set_chk(5'd1, 5'd2, 5'd3);
      rst = 1'b1;

      // Reset with all sources presenting
      bus.lsu_wb_valid = 1'b1; bus.lsu_wb_idx = 5'd10; bus.lsu_wb_dat = 32'h1010;
      bus.mdu_wb_valid = 1'b1; bus.mdu_wb_idx = 5'd11; bus.mdu_wb_dat = 32'h1111;
      bus.alu_wb_valid = 1'b1; bus.alu_wb_en  = 1'b1;
      bus.alu_wb_idx   = 5'd12; bus.alu_wb_dat = 32'h1212;
      step();
      step();
      chk("rst_wen", bus.wb_dest_wen, 0);
      chk("rst_idx", bus.wb_dest_idx, 0);
      chk("rst_dat", bus.wb_dest_dat, 0);
      rst = 1'b0;
      step();
      step();
      step();
      step();

      // Priority collision
      bus.lsu_wb_valid = 1'b1; bus.lsu_wb_idx = 5'd5; bus.lsu_wb_dat = 32'hAAAA;
      bus.mdu_wb_valid = 1'b1; bus.mdu_wb_idx = 5'd6; bus.mdu_wb_dat = 32'hBBBB;
      bus.alu_wb_valid = 1'b1; bus.alu_wb_en  = 1'b1;
      bus.alu_wb_idx   = 5'd7; bus.alu_wb_dat = 32'hCCCC;
      for (int i = 0; i < 4; i++) step();
      chk("collision_rf_x7", rf[7], 32'hCCCC);

      // x0 writes and retire-without-write
      bus.alu_wb_valid = 1'b1; bus.alu_wb_en = 1'b1; bus.alu_wb_idx = 5'd0; bus.alu_wb_dat = 32'h1234;
      step();
      chk("x0_wen", bus.wb_dest_wen, 0);
      bus.alu_wb_valid = 1'b1; bus.alu_wb_en = 1'b0; bus.alu_wb_idx = 5'd3; bus.alu_wb_dat = 32'h3333;
      step();
      chk("retire_wen", bus.wb_dest_wen, 0);
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd0;
      step();
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd0;
      step();
      step();
      chk("x0_issue_no_err", bus.sb_err, 0);

      // Scoreboard stall around a load to x9
      set_chk(5'd9, 5'd0, 5'd0);
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd9;
      step();
      chk("haz_after_issue", bus.hazard, 1);
      step();
      step();
      bus.lsu_wb_valid = 1'b1; bus.lsu_wb_idx = 5'd9; bus.lsu_wb_dat = 32'h55;
      step();
      chk("haz_n_plus_1", bus.hazard, 1);
      step();
      chk("haz_n_plus_2", bus.hazard, 0);
      chk("rf_x9", rf[9], 32'h55);

      // Set/clear race on x4, then double issue
      set_chk(5'd0, 5'd4, 5'd0);
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd4;
      step();
      bus.mdu_wb_valid = 1'b1; bus.mdu_wb_idx = 5'd4; bus.mdu_wb_dat = 32'h4444;
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd4;
      step();
      chk("race_no_err", bus.sb_err, 0);
      step();
      step();
      chk("race_pend_kept", bus.hazard, 1);
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd4;
      step();
      chk("double_issue_err", bus.sb_err, 1);
      step();
      step();
      chk("err_sticky", bus.sb_err, 1);

      // Reset while a write to x8 sits in the output stage
      set_chk(5'd8, 5'd0, 5'd0);
      bus.lt_issue_valid = 1'b1; bus.lt_issue_idx = 5'd8;
      step();
      saved = rf[8];
      bus.lsu_wb_valid = 1'b1; bus.lsu_wb_idx = 5'd8; bus.lsu_wb_dat = 32'hDEAD_BEEF;
      step();
      chk("midflight_wen_before", bus.wb_dest_wen, 1);
      rst = 1'b1;
      clear_inputs();
      #1;
      chk("midflight_wen_drop", bus.wb_dest_wen, 0);
      chk("midflight_hazard", bus.hazard, 0);
      chk("midflight_err_clr", bus.sb_err, 0);
      model_reset();
      #1;
      rst = 1'b0;
      step();
      step();
      chk("midflight_rf_x8", rf[8], saved);

      // Random traffic
      for (int c = 0; c < 1500; c++) begin
         if (!bus.lsu_wb_valid && $urandom_range(0, 9) < 3) begin
            bus.lsu_wb_valid = 1'b1;
            bus.lsu_wb_idx   = 5'($urandom_range(0, 31));
            bus.lsu_wb_dat   = $urandom;
         end
         if (!bus.mdu_wb_valid && $urandom_range(0, 9) < 3) begin
            bus.mdu_wb_valid = 1'b1;
            bus.mdu_wb_idx   = 5'($urandom_range(0, 31));
            bus.mdu_wb_dat   = $urandom;
         end
         if (!bus.alu_wb_valid && $urandom_range(0, 9) < 5) begin
            bus.alu_wb_valid = 1'b1;
            bus.alu_wb_en    = 1'($urandom_range(0, 1));
            bus.alu_wb_idx   = 5'($urandom_range(0, 31));
            bus.alu_wb_dat   = $urandom;
         end
         bus.lt_issue_valid = ($urandom_range(0, 9) < 2);
         bus.lt_issue_idx   = 5'($urandom_range(0, 31));
         set_chk(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         step();
      end

      // Drain
      bus.lt_issue_valid = 1'b0;
      for (int c = 0; c < 8; c++) step();
      chk("drain_queue_empty", 64'(exp_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
